// File: rtl/axis_block_framer.sv
// AXI-Stream block/frame framer with 2-entry registered skid output and flush padding.
// Optional frame_count port is built only when AXIS_BLOCK_FRAMER_STATS_EN is defined.
`timescale 1ns/1ps
module axis_block_framer #(
    parameter int DATA_WIDTH  = 32,
    parameter int OUTPUT_BDIM = 16,
    parameter int OUTPUT_SDIM = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_input_tdata,
    input  logic                  s_axis_input_tvalid,
    output logic                  s_axis_input_tready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_axis_output_tdata,
    output logic                  m_axis_output_tvalid,
    input  logic                  m_axis_output_tready,
    output logic                  m_axis_output_tlast,
`ifdef AXIS_BLOCK_FRAMER_STATS_EN
    output logic [31:0]           frame_count,
`endif
    output logic                  m_axis_output_tuser
);

    localparam int BLOCKS = OUTPUT_SDIM / OUTPUT_BDIM;
    localparam int BW = (OUTPUT_BDIM > 1) ? $clog2(OUTPUT_BDIM) : 1;
    localparam int KW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(OUTPUT_BDIM - 1);
    localparam logic [KW-1:0] BLK_MAX = KW'(BLOCKS - 1);

    if (OUTPUT_BDIM < 1 || OUTPUT_BDIM > 65535 ||
        OUTPUT_SDIM < OUTPUT_BDIM || (OUTPUT_SDIM % OUTPUT_BDIM) != 0) begin : g_bad_dims
        $error("axis_block_framer: illegal OUTPUT_BDIM/OUTPUT_SDIM");
    end

    typedef enum logic [1:0] {IDLE, FILL, PAD} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [KW-1:0]         blk_q, blk_d;
    logic                  rdy_q, rdy_d;
    // Entry 0 drives the output port; entry 1 is the skid slot.
    logic                  ov_q, ov_d, ol_q, ol_d, ou_q, ou_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic                  sv_q, sv_d, sl_q, sl_d, su_q, su_d;
    logic [DATA_WIDTH-1:0] sd_q, sd_d;

    logic                  accept, pad_push, push, pop, in_last, in_user;
    logic [DATA_WIDTH-1:0] in_data;

    assign accept   = s_axis_input_tvalid & rdy_q;
    assign pad_push = (state_q == PAD) & ~sv_q;
    assign push     = accept | pad_push;
    assign pop      = ov_q & m_axis_output_tready;
    assign in_data  = accept ? s_axis_input_tdata : '0;
    assign in_last  = (beat_q == BEAT_MAX);
    assign in_user  = in_last & (blk_q == BLK_MAX);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        blk_d   = blk_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        ou_d    = ou_q;
        sv_d    = sv_q;
        sd_d    = sd_q;
        sl_d    = sl_q;
        su_d    = su_q;

        if (!ov_q || pop) begin
            if (sv_q) begin
                ov_d = 1'b1;
                od_d = sd_q;
                ol_d = sl_q;
                ou_d = su_q;
                sv_d = push;
                if (push) begin
                    sd_d = in_data;
                    sl_d = in_last;
                    su_d = in_user;
                end
            end else begin
                ov_d = push;
                if (push) begin
                    od_d = in_data;
                    ol_d = in_last;
                    ou_d = in_user;
                end
            end
        end else if (push) begin
            sv_d = 1'b1;
            sd_d = in_data;
            sl_d = in_last;
            su_d = in_user;
        end

        if (push) begin
            if (in_last) begin
                beat_d = '0;
                blk_d  = (blk_q == BLK_MAX) ? '0 : blk_q + KW'(1);
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end

        unique case (state_q)
            IDLE: if (accept && !in_last) state_d = FILL;
            FILL: begin
                if (accept && in_last) state_d = IDLE;
                else if (flush) state_d = PAD;
            end
            PAD:  if (pad_push && in_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdy_d = (state_d != PAD) && !(ov_d && sv_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            blk_q   <= '0;
            rdy_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            ou_q    <= 1'b0;
            sv_q    <= 1'b0;
            sd_q    <= '0;
            sl_q    <= 1'b0;
            su_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
            rdy_q   <= rdy_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            ou_q    <= ou_d;
            sv_q    <= sv_d;
            sd_q    <= sd_d;
            sl_q    <= sl_d;
            su_q    <= su_d;
        end
    end

`ifdef AXIS_BLOCK_FRAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= 32'd0;
        end else if (pop && ou_q) begin
            frame_count <= frame_count + 32'd1;
        end
    end
`endif

    assign s_axis_input_tready  = rdy_q;
    assign m_axis_output_tdata  = od_q;
    assign m_axis_output_tvalid = ov_q;
    assign m_axis_output_tlast  = ol_q;
    assign m_axis_output_tuser  = ou_q;

endmodule

// File: tb/tb_axis_block_framer.sv
// Bench for axis_block_framer: frame-position/occupancy model plus directed and random traffic.
`timescale 1ns/1ps
module tb_axis_block_framer;
    localparam int DW = 32;
    localparam int B  = 4;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          flush = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
`ifdef AXIS_BLOCK_FRAMER_STATS_EN
    logic [31:0]   frame_count;
`endif

    int vec = 0;
    int err = 0;
    int mode = 0;

    // Model: n = entries held, r = pad beats still owed, p = position in frame
    int n = 0, r = 0, p = 0, fc = 0;
    bit exp_rdy = 1'b0;
    bit model_ok = 1'b0;
    logic [33:0] expq[$];
    logic [31:0] log_d[$];
    bit log_l[$];
    bit log_u[$];

    axis_block_framer #(
        .DATA_WIDTH (DW),
        .OUTPUT_BDIM(B),
        .OUTPUT_SDIM(S)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_input_tdata  (s_tdata),
        .s_axis_input_tvalid (s_tvalid),
        .s_axis_input_tready (s_tready),
        .flush               (flush),
        .m_axis_output_tdata (m_tdata),
        .m_axis_output_tvalid(m_tvalid),
        .m_axis_output_tready(m_tready),
        .m_axis_output_tlast (m_tlast),
`ifdef AXIS_BLOCK_FRAMER_STATS_EN
        .frame_count         (frame_count),
`endif
        .m_axis_output_tuser (m_tuser)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Negedge: compare current outputs, then advance the model across the next edge
    always @(negedge clk) begin : mdl
        bit acc, pop, pushed;
        int pb;
        logic [33:0] e;
        if (model_ok) begin
            chk("out_tvalid", m_tvalid, n > 0);
            if (n > 0 && expq.size() > 0) begin
                e = expq[0];
                chk("out_tdata", m_tdata, e[31:0]);
                chk("out_tlast", m_tlast, e[32]);
                chk("out_tuser", m_tuser, e[33]);
            end
            chk("in_tready", s_tready, exp_rdy);
`ifdef AXIS_BLOCK_FRAMER_STATS_EN
            chk("frame_count", frame_count, fc);
`endif
        end
        if (reset) begin
            n = 0; r = 0; p = 0; fc = 0;
            expq.delete();
            exp_rdy = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            acc = s_tvalid && s_tready;
            pop = m_tvalid && m_tready;
            pushed = 1'b0;
            pb = p % B;
            if (pop) begin
                log_d.push_back(m_tdata);
                log_l.push_back(m_tlast);
                log_u.push_back(m_tuser);
                if (expq.size() > 0) begin
                    if (expq[0][33]) fc++;
                    void'(expq.pop_front());
                end
            end
            if (r > 0) begin
                if (n < 2) begin
                    e = {(p == S - 1), (p % B == B - 1), 32'h0};
                    expq.push_back(e);
                    p = (p + 1) % S;
                    r--;
                    pushed = 1'b1;
                end
            end else if (acc) begin
                e = {(p == S - 1), (p % B == B - 1), s_tdata};
                expq.push_back(e);
                p = (p + 1) % S;
                pushed = 1'b1;
                if (flush && pb != 0 && (p % B) != 0) r = B - (p % B);
            end else if (flush && pb != 0) begin
                r = B - pb;
            end
            n = n + int'(pushed) - int'(pop);
            if (n < 0) n = 0;
            exp_rdy = (n < 2) && (r == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: m_tready = 1'b1;
                1: m_tready = ~m_tready;
                2: m_tready = ($urandom % 10) < 6;
                default: m_tready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [31:0] d);
        bit acc;
        s_tvalid = 1'b1;
        s_tdata  = d;
        acc = 1'b0;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            vec++;
            err++;
            $display("FAIL send_timeout: tready stayed 0, beat %0h not taken", d);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            done = (n == 0) && (r == 0) && !m_tvalid;
        end
        chk("drain_done", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_l.delete();
        log_u.delete();
    endtask

    initial begin : wdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] exp3[4];
        bit lst[4];
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tuser", m_tuser, 0);
        chk("rst_tready", s_tready, 0);
`ifdef AXIS_BLOCK_FRAMER_STATS_EN
        chk("rst_frames", frame_count, 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", s_tready, 1);

        // 8 beats, one full frame, tready held high
        clear_log();
        send(32'd1);
        chk("lat_tvalid", m_tvalid, 1);
        chk("lat_tdata", m_tdata, 1);
        for (int i = 2; i <= 8; i++) send(i);
        s_tvalid = 1'b0;
        drain();
        chk("p2_count", log_d.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_d.size()) begin
                chk("p2_data", log_d[i], i + 1);
                chk("p2_last", log_l[i], (i == 3 || i == 7));
                chk("p2_user", log_u[i], (i == 7));
            end
        end
`ifdef AXIS_BLOCK_FRAMER_STATS_EN
        chk("p2_frames", frame_count, 1);
`endif

        // Two beats then flush pads the block with zeros
        clear_log();
        send(32'hA);
        send(32'hB);
        s_tvalid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("pad_rdy_low", s_tready, 0);
        drain();
        exp3 = '{32'hA, 32'hB, 32'h0, 32'h0};
        lst  = '{1'b0, 1'b0, 1'b0, 1'b1};
        chk("p3_count", log_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_d.size()) begin
                chk("p3_data", log_d[i], exp3[i]);
                chk("p3_last", log_l[i], lst[i]);
                chk("p3_user", log_u[i], 0);
            end
        end

        // Continuous input against alternating downstream ready
        clear_log();
        mode = 1;
        for (int i = 0; i < 24; i++) send(32'h100 + i);
        s_tvalid = 1'b0;
        drain();
        mode = 0;
        chk("p4_count", log_d.size(), 24);
        for (int i = 0; i < 24; i++) begin
            if (i < log_d.size()) chk("p4_data", log_d[i], 32'h100 + i);
        end

        // Reset with beats buffered: nothing stale may come out afterwards
        mode = 3;
        send(32'h31);
        send(32'h32);
        s_tvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("p5_rst_tvalid", m_tvalid, 0);
        chk("p5_rst_tdata", m_tdata, 0);
        chk("p5_rst_tlast", m_tlast, 0);
        chk("p5_rst_tready", s_tready, 0);
        reset = 1'b0;
        mode = 0;
        clear_log();
        @(posedge clk);
        #1;
        chk("p5_rdy", s_tready, 1);
        for (int i = 1; i <= 4; i++) send(32'h40 + i);
        s_tvalid = 1'b0;
        drain();
        chk("p5_count", log_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_d.size()) begin
                chk("p5_data", log_d[i], 32'h41 + i);
                chk("p5_last", log_l[i], (i == 3));
            end
        end

        // Random traffic, flushes and occasional resets
        mode = 2;
        repeat (3000) begin
            s_tvalid = ($urandom % 10) < 7;
            s_tdata  = $urandom;
            flush    = ($urandom % 16) == 0;
            reset    = ($urandom % 700) == 0;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
